// File: rtl/apex7_seq_ctrl_if.sv
// Request/grant bundle between the requesters and apex7_seq_ctrl.
// The tmo flag is present only when APEX7_SEQ_TIMEOUT_EN is defined.
interface apex7_seq_ctrl_if;
  logic [5:0] req;
  logic       busy;
  logic [3:0] cfg_len;
  logic [5:0] grant;
  logic [2:0] sel;
  logic       start;
  logic [3:0] beat_cnt;
  logic       done;
`ifdef APEX7_SEQ_TIMEOUT_EN
  logic       tmo;

  modport master (
    output req, busy, cfg_len,
    input  grant, sel, start, beat_cnt, done, tmo
  );
  modport slave (
    input  req, busy, cfg_len,
    output grant, sel, start, beat_cnt, done, tmo
  );
`else
  modport master (
    output req, busy, cfg_len,
    input  grant, sel, start, beat_cnt, done
  );
  modport slave (
    input  req, busy, cfg_len,
    output grant, sel, start, beat_cnt, done
  );
`endif
endinterface

// File: rtl/apex7_seq_ctrl.sv
// Six-way round-robin sequencer granting a shared resource for bursts of cfg_len+1 beats.
// Optional busy-stall abort is enabled by defining APEX7_SEQ_TIMEOUT_EN.
module apex7_seq_ctrl #(
  parameter int unsigned TMO_CYC = 16
) (
  input  logic           clock,
  input  logic           reset,
  apex7_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StGrant, StXfer, StDone} state_e;

  state_e     state_q;
  logic [5:0] grant_q;
  logic [2:0] sel_q;
  logic [2:0] last_q;
  logic       start_q;
  logic       done_q;
  logic [3:0] beat_q;

  logic       pick_found;
  logic [2:0] pick_idx;

`ifdef APEX7_SEQ_TIMEOUT_EN
  localparam int unsigned TcW = $clog2(TMO_CYC + 1);
  localparam logic [TcW-1:0] TcLast = TcW'(TMO_CYC - 1);

  logic [TcW-1:0] tcnt_q;
  logic           tmo_q;
`endif

  // (base + off) mod 6, valid for base <= 5 and off <= 6.
  function automatic logic [2:0] wrap_add(input logic [2:0] base, input logic [2:0] off);
    logic [3:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (s >= 4'd6) s = s - 4'd6;
    return s[2:0];
  endfunction

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 3'd0;
    for (int k = 1; k <= 6; k++) begin
      if (!pick_found && bus.req[wrap_add(last_q, 3'(k))]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_add(last_q, 3'(k));
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      sel_q   <= '0;
      last_q  <= 3'd5;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      beat_q  <= '0;
`ifdef APEX7_SEQ_TIMEOUT_EN
      tcnt_q  <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef APEX7_SEQ_TIMEOUT_EN
      tmo_q   <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          if (pick_found) begin
            grant_q <= 6'(1) << pick_idx;
            sel_q   <= pick_idx;
            start_q <= 1'b1;
            state_q <= StGrant;
          end
        end
        StGrant: begin
          beat_q  <= bus.cfg_len;
          state_q <= StXfer;
`ifdef APEX7_SEQ_TIMEOUT_EN
          tcnt_q  <= '0;
`endif
        end
        StXfer: begin
          if (!bus.busy) begin
`ifdef APEX7_SEQ_TIMEOUT_EN
            tcnt_q <= '0;
`endif
            if (beat_q == 4'd0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              beat_q <= beat_q - 4'd1;
            end
          end
`ifdef APEX7_SEQ_TIMEOUT_EN
          // Abort lands in DONE exactly TMO_CYC busy cycles after the stall began.
          else if (tcnt_q == TcLast) begin
            state_q <= StDone;
            done_q  <= 1'b1;
            tmo_q   <= 1'b1;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
`endif
        end
        StDone: begin
          last_q  <= sel_q;
          grant_q <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.grant    = grant_q;
  assign bus.sel      = sel_q;
  assign bus.start    = start_q;
  assign bus.beat_cnt = beat_q;
  assign bus.done     = done_q;
`ifdef APEX7_SEQ_TIMEOUT_EN
  assign bus.tmo      = tmo_q;
`endif

endmodule

// File: tb/tb_apex7_seq_ctrl.sv
// Scoreboard bench for apex7_seq_ctrl: stimulus queues expected start/done events,
// a negedge monitor pops and compares them. Honours APEX7_SEQ_TIMEOUT_EN when defined.
module tb_apex7_seq_ctrl;

  typedef struct {
    logic [5:0] grant;
    logic [2:0] sel;
    int         cyc;
    logic       tmo;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   done_seen = 0;

  exp_t start_q[$];
  exp_t done_q[$];

  apex7_seq_ctrl_if bus ();

  apex7_seq_ctrl #(.TMO_CYC(16)) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push(input bit is_done, input int idx, input int at_cyc,
                               input logic tmo);
    exp_t e;
    e.grant = 6'(1) << idx;
    e.sel   = 3'(idx);
    e.cyc   = at_cyc;
    e.tmo   = tmo;
    if (is_done) done_q.push_back(e);
    else start_q.push_back(e);
  endfunction

  // One transfer starting in the current IDLE cycle; returns in the following IDLE cycle.
  // done_off is the hand-computed DONE cycle offset from the request cycle.
  task automatic run_xfer(input logic [5:0] r, input logic [3:0] len, input logic [15:0] bmask,
                          input bit hold, input int idx, input int done_off);
    int         t0;
    logic [3:0] bc;
    t0 = cyc;
    bus.req     = r;
    bus.cfg_len = len;
    bus.busy    = 1'b0;
    push(1'b0, idx, t0 + 1, 1'b0);
    push(1'b1, idx, t0 + done_off, 1'b0);
    tick();
    if (!hold) bus.req = '0;
    bc = len;
    for (int j = 0; j < done_off - 2; j++) begin
      tick();
      bus.busy = bmask[j];
      chk("beat_cnt", 32'(bus.beat_cnt), 32'(bc));
      chk("grant_stable_xfer", 32'(bus.grant), 32'(6'(1) << idx));
      if (!bmask[j] && bc != 4'd0) bc = bc - 4'd1;
    end
    tick();
    bus.busy = 1'b0;
    tick();
    chk("grant_clear_after_done", 32'(bus.grant), 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.start) begin
      if (start_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL start_unexpected @cyc %0d: got grant %0h, none pending", cyc, bus.grant);
      end else begin
        e = start_q.pop_front();
        chk("start_grant", 32'(bus.grant), 32'(e.grant));
        chk("start_sel", 32'(bus.sel), 32'(e.sel));
        chk("start_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (bus.done) begin
      done_seen++;
      if (done_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL done_unexpected @cyc %0d: got grant %0h, none pending", cyc, bus.grant);
      end else begin
        e = done_q.pop_front();
        chk("done_grant", 32'(bus.grant), 32'(e.grant));
        chk("done_sel", 32'(bus.sel), 32'(e.sel));
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
`ifdef APEX7_SEQ_TIMEOUT_EN
        chk("done_tmo", 32'(bus.tmo), 32'(e.tmo));
`endif
      end
    end
`ifdef APEX7_SEQ_TIMEOUT_EN
    if (bus.tmo && !bus.done) begin
      n_checks++;
      n_fail++;
      $display("FAIL tmo_without_done @cyc %0d: got tmo 1 done 0", cyc);
    end
`endif
  end

  initial begin
    int t0;
    int ds;
    reset       = 1'b1;
    bus.req     = '0;
    bus.busy    = 1'b0;
    bus.cfg_len = '0;
    repeat (3) tick();
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_sel", 32'(bus.sel), 32'd0);
    chk("rst_start", 32'(bus.start), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_beat_cnt", 32'(bus.beat_cnt), 32'd0);

    // Single beat right after reset release: grant c1, done c3, idle c4.
    reset = 1'b0;
    run_xfer(6'b000001, 4'd0, 16'h0, 1'b0, 0, 3);

    // Full request vector held: 0..5 then 0 again, 4-cycle cadence.
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    for (int k = 0; k < 7; k++) run_xfer(6'h3f, 4'd0, 16'h0, 1'b1, k % 6, 3);
    bus.req = '0;

    // Build last=3, then wrap-around past 5 picks 0, then 3.
    run_xfer(6'b001000, 4'd0, 16'h0, 1'b0, 3, 3);
    run_xfer(6'b001001, 4'd0, 16'h0, 1'b1, 0, 3);
    run_xfer(6'b001001, 4'd0, 16'h0, 1'b0, 3, 3);

    // cfg_len=3 with busy on XFER cycles 1 and 3: beat_cnt 3,2,2,1,1,0, done 7 after GRANT.
    run_xfer(6'b000010, 4'd3, 16'b001010, 1'b0, 1, 8);

    // Reset mid-transfer with beat_cnt=5; priority returns to requester 0 side.
    t0 = cyc;
    bus.req     = 6'b000110;
    bus.cfg_len = 4'd5;
    bus.busy    = 1'b0;
    push(1'b0, 2, t0 + 1, 1'b0);
    tick();
    tick();
    chk("beat_cnt_pre_reset", 32'(bus.beat_cnt), 32'd5);
    reset = 1'b1;
    tick();
    chk("midrst_grant", 32'(bus.grant), 32'd0);
    chk("midrst_sel", 32'(bus.sel), 32'd0);
    chk("midrst_start", 32'(bus.start), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_beat_cnt", 32'(bus.beat_cnt), 32'd0);
`ifdef APEX7_SEQ_TIMEOUT_EN
    chk("midrst_tmo", 32'(bus.tmo), 32'd0);
`endif
    reset = 1'b0;
    run_xfer(6'b000110, 4'd0, 16'h0, 1'b0, 1, 3);

    // Busy held through XFER.
    t0 = cyc;
    bus.req     = 6'b000001;
    bus.cfg_len = 4'd0;
    bus.busy    = 1'b1;
    push(1'b0, 0, t0 + 1, 1'b0);
`ifdef APEX7_SEQ_TIMEOUT_EN
    push(1'b1, 0, t0 + 18, 1'b1);
    tick();
    bus.req = '0;
    repeat (18) tick();
    chk("grant_clear_after_tmo", 32'(bus.grant), 32'd0);
    bus.busy = 1'b0;
`else
    tick();
    bus.req = '0;
    ds = done_seen;
    repeat (40) tick();
    chk("no_done_while_busy", 32'(done_seen), 32'(ds));
    chk("grant_held_while_busy", 32'(bus.grant), 32'b000001);
    push(1'b1, 0, t0 + 42, 1'b0);
    bus.busy = 1'b0;
    tick();
    tick();
    chk("grant_clear_after_stall", 32'(bus.grant), 32'd0);
`endif

    repeat (3) tick();
    chk("start_queue_drained", 32'(start_q.size()), 32'd0);
    chk("done_queue_drained", 32'(done_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
